writeback_unit: RTL and testbench

Register-write (RW) stage of the pipelined TinyRISC core: the write-side counterpart to operand fetch and decode. It accepts one retiring instruction per handshake from the memory-access stage, waits for load data when needed, selects the write-back value (ALU result, load data, or return address), and drives the single write port of `Register_file`. It also presents the in-flight write as a forwarding source for the decode stage.

---
 rtl/writeback_unit.sv | 129 ++++++++++++
 tb/tb_writeback_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: register-write stage of the TinyRISC pipeline; drives the single register-file write port.
// Latency: a non-load writes one cycle after acceptance; a load writes one cycle after its ld_data_valid edge.
// Backpressure: in_ready is low only while waiting for load data; back-to-back non-loads run at one per cycle.
//
// Ports:
//    clock, reset            clock, asynchronous active-low reset
//    in_valid/in_ready       handshake from the memory-access stage
//    in_pc, in_alu_result    instruction PC and ALU/EX result
//    in_rd, in_isWb          destination register and write flag
//    in_isLd, in_isCall      load (value from ld_data) / call (writes pc+4 to r15)
//    ld_data_valid, ld_data  load data return from data memory
//    reg_wr1, reg_wr1_data,  register file write port
//    wr1_enable
//    fwd_valid/reg/data      forwarding source for decode (mirror of the write port)
//    busy                    high whenever an instruction is held
//    instret                 retired-instruction count (only with WB_RETIRE_CNT_EN)
//
// Optional feature: define WB_RETIRE_CNT_EN to add the instret port and counter.

module writeback_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_alu_result,
   input  logic [3:0]  in_rd,
   input  logic        in_isWb,
   input  logic        in_isLd,
   input  logic        in_isCall,
   input  logic        ld_data_valid,
   input  logic [31:0] ld_data,
   output logic [3:0]  reg_wr1,
   output logic [31:0] reg_wr1_data,
   output logic        wr1_enable,
   output logic        fwd_valid,
   output logic [3:0]  fwd_reg,
   output logic [31:0] fwd_data,
   output logic        busy
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0] instret
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_LD = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wr_rd_q;
   logic [31:0] wr_data_q;
   logic        wb_q;
   logic        call_q;
   logic        accept;
   logic        ld_capture;

   // in_ready depends on registered state only, so accept has no path to outputs.
   assign in_ready   = (state_q != S_WAIT_LD);
   assign accept     = in_valid & in_ready;
   assign ld_capture = (state_q == S_WAIT_LD) & ld_data_valid;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = in_isLd ? S_WAIT_LD : S_COMMIT;
         end
         S_WAIT_LD: begin
            if (ld_capture) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            if (accept) state_d = in_isLd ? S_WAIT_LD : S_COMMIT;
            else        state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Destination and value are resolved at acceptance so the write port is a
   // plain register read-out. For loads the ALU value is held only until the
   // returning ld_data replaces it, unless the instruction is also a call, which
   // has higher data priority and keeps pc+4.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         wr_rd_q   <= 4'd0;
         wr_data_q <= 32'd0;
         wb_q      <= 1'b0;
         call_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wr_rd_q   <= in_isCall ? 4'd15 : in_rd;
            wr_data_q <= in_isCall ? (in_pc + 32'd4) : in_alu_result;
            wb_q      <= in_isWb;
            call_q    <= in_isCall;
         end else if (ld_capture && !call_q) begin
            wr_data_q <= ld_data;
         end
      end
   end

   assign wr1_enable   = (state_q == S_COMMIT) & wb_q;
   assign reg_wr1      = wr_rd_q;
   assign reg_wr1_data = wr_data_q;
   assign fwd_valid    = wr1_enable;
   assign fwd_reg      = wr_rd_q;
   assign fwd_data     = wr_data_q;
   assign busy         = (state_q != S_IDLE);

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] instret_q;

   // Every COMMIT cycle retires one instruction, writing or not; wraps naturally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instret_q <= 32'd0;
      end else if (state_q == S_COMMIT) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_alu_result;
   logic [3:0]  in_rd;
   logic        in_isWb;
   logic        in_isLd;
   logic        in_isCall;
   logic        ld_data_valid;
   logic [31:0] ld_data;
   logic [3:0]  reg_wr1;
   logic [31:0] reg_wr1_data;
   logic        wr1_enable;
   logic        fwd_valid;
   logic [3:0]  fwd_reg;
   logic [31:0] fwd_data;
   logic        busy;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] instret;
`endif

   writeback_unit dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_alu_result (in_alu_result),
      .in_rd         (in_rd),
      .in_isWb       (in_isWb),
      .in_isLd       (in_isLd),
      .in_isCall     (in_isCall),
      .ld_data_valid (ld_data_valid),
      .ld_data       (ld_data),
      .reg_wr1       (reg_wr1),
      .reg_wr1_data  (reg_wr1_data),
      .wr1_enable    (wr1_enable),
      .fwd_valid     (fwd_valid),
      .fwd_reg       (fwd_reg),
      .fwd_data      (fwd_data),
      .busy          (busy)
`ifdef WB_RETIRE_CNT_EN
      ,
      .instret       (instret)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // One instruction may be waiting for load data; at most one commit is
   // visible per cycle. Values are computed straight from the write rules.
   logic        m_pend;
   logic        m_pend_wb;
   logic        m_pend_call;
   logic [3:0]  m_pend_rd;
   logic [31:0] m_pend_data;
   logic        m_c_vld;
   logic        m_c_wb;
   logic [3:0]  m_c_rd;
   logic [31:0] m_c_data;
   logic [31:0] m_ret;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pend  = 1'b0;
         m_c_vld = 1'b0;
         m_c_wb  = 1'b0;
         m_c_rd  = 4'd0;
         m_c_data = 32'd0;
         m_ret   = 32'd0;
      end else begin
         if (m_c_vld) m_ret = m_ret + 32'd1;
         m_c_vld = 1'b0;
         if (m_pend) begin
            if (ld_data_valid) begin
               m_c_vld  = 1'b1;
               m_c_wb   = m_pend_wb;
               m_c_rd   = m_pend_rd;
               m_c_data = m_pend_call ? m_pend_data : ld_data;
               m_pend   = 1'b0;
            end
         end else if (in_valid) begin
            if (in_isLd) begin
               m_pend      = 1'b1;
               m_pend_wb   = in_isWb;
               m_pend_call = in_isCall;
               m_pend_rd   = in_isCall ? 4'd15 : in_rd;
               m_pend_data = in_pc + 32'd4;
            end else begin
               m_c_vld  = 1'b1;
               m_c_wb   = in_isWb;
               m_c_rd   = in_isCall ? 4'd15 : in_rd;
               m_c_data = in_isCall ? (in_pc + 32'd4) : in_alu_result;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         chk("model in_ready",   {31'd0, in_ready},   {31'd0, !m_pend});
         chk("model busy",       {31'd0, busy},       {31'd0, m_pend | m_c_vld});
         chk("model wr1_enable", {31'd0, wr1_enable}, {31'd0, m_c_vld & m_c_wb});
         chk("model fwd_valid",  {31'd0, fwd_valid},  {31'd0, m_c_vld & m_c_wb});
         if (m_c_vld && m_c_wb) begin
            chk("model reg_wr1",      {28'd0, reg_wr1}, {28'd0, m_c_rd});
            chk("model reg_wr1_data", reg_wr1_data,     m_c_data);
            chk("model fwd_reg",      {28'd0, fwd_reg}, {28'd0, m_c_rd});
            chk("model fwd_data",     fwd_data,         m_c_data);
         end
`ifdef WB_RETIRE_CNT_EN
         chk("model instret", instret, m_ret);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [3:0] rd,
                        input logic wb, input logic ld, input logic call);
      in_valid      = 1'b1;
      in_pc         = pc;
      in_alu_result = alu;
      in_rd         = rd;
      in_isWb       = wb;
      in_isLd       = ld;
      in_isCall     = call;
   endtask

   task automatic idle_in();
      in_valid  = 1'b0;
      in_isWb   = 1'b0;
      in_isLd   = 1'b0;
      in_isCall = 1'b0;
   endtask

   task automatic chk_write(input string name, input logic [3:0] rd, input logic [31:0] data);
      chk({name, " wr1_enable"},   {31'd0, wr1_enable}, 32'd1);
      chk({name, " reg_wr1"},      {28'd0, reg_wr1},    {28'd0, rd});
      chk({name, " reg_wr1_data"}, reg_wr1_data,        data);
      chk({name, " fwd_valid"},    {31'd0, fwd_valid},  32'd1);
      chk({name, " fwd_reg"},      {28'd0, fwd_reg},    {28'd0, rd});
      chk({name, " fwd_data"},     fwd_data,            data);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, " wr1_enable"},   {31'd0, wr1_enable}, 32'd0);
      chk({name, " in_ready"},     {31'd0, in_ready},   32'd1);
      chk({name, " busy"},         {31'd0, busy},       32'd0);
      chk({name, " fwd_valid"},    {31'd0, fwd_valid},  32'd0);
   endtask

   logic [3:0]  b2b_rd   [5] = '{4'd1, 4'd2, 4'd0, 4'd4, 4'd6};
   logic [31:0] b2b_data [5] = '{32'h11, 32'h22, 32'hA5, 32'h44, 32'h99};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      in_pc = 32'd0;
      in_alu_result = 32'd0;
      in_rd = 4'd0;
      ld_data_valid = 1'b0;
      ld_data = 32'd0;
      idle_in();

      // reset state
      @(negedge clock);
      @(negedge clock);
      chk_quiet("reset");
      chk("reset reg_wr1",      {28'd0, reg_wr1}, 32'd0);
      chk("reset reg_wr1_data", reg_wr1_data,     32'd0);
      chk("reset fwd_data",     fwd_data,         32'd0);
      reset = 1'b1;

      // ALU write r3 = 0x1234 for exactly one cycle
      @(negedge clock);
      drive(32'h100, 32'h1234, 4'd3, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      idle_in();
      chk_write("alu", 4'd3, 32'h1234);
      @(negedge clock);
      chk_quiet("alu after");

      // Load r5 with three idle strobe cycles, then DEADBEEF
      drive(32'h104, 32'h55, 4'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      idle_in();
      for (int i = 0; i < 3; i++) begin
         chk("load wait in_ready",   {31'd0, in_ready},   32'd0);
         chk("load wait wr1_enable", {31'd0, wr1_enable}, 32'd0);
         @(negedge clock);
      end
      ld_data_valid = 1'b1;
      ld_data       = 32'hDEADBEEF;
      chk("load strobe in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
      ld_data_valid = 1'b0;
      chk_write("load", 4'd5, 32'hDEADBEEF);

      // Call at the top of the address space: r15 gets pc+4 wrapped to 0
      @(negedge clock);
      drive(32'hFFFFFFFC, 32'h9, 4'd2, 1'b1, 1'b0, 1'b1);
      @(negedge clock);
      idle_in();
      chk_write("call", 4'd15, 32'h0);

      // Reset mid-WAIT_LD, then a late strobe must be ignored
      @(negedge clock);
      drive(32'h200, 32'h77, 4'd9, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      idle_in();
      chk("rst pre busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk_quiet("rst async");
      chk("rst async reg_wr1",      {28'd0, reg_wr1}, 32'd0);
      chk("rst async reg_wr1_data", reg_wr1_data,     32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      ld_data_valid = 1'b1;
      ld_data       = 32'hBAD0BAD0;
      @(negedge clock);
      ld_data_valid = 1'b0;
      chk_quiet("rst late strobe");
`ifdef WB_RETIRE_CNT_EN
      chk("rst instret", instret, 32'd0);
`endif

      // Back-to-back: four ALU writes (one to r0), then a store
      @(negedge clock);
      drive(32'h300, b2b_data[0], b2b_rd[0], 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) begin
         @(negedge clock);
         chk_write("b2b", b2b_rd[i-1], b2b_data[i-1]);
         drive(32'h300 + 32'(4 * i), b2b_data[i], b2b_rd[i], (i < 4), 1'b0, 1'b0);
      end
      @(negedge clock);
      idle_in();
      chk("store wr1_enable", {31'd0, wr1_enable}, 32'd0);
      chk("store busy",       {31'd0, busy},       32'd1);
      @(negedge clock);
      chk_quiet("b2b done");
`ifdef WB_RETIRE_CNT_EN
      chk("b2b instret", instret, 32'd5);
`endif

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
